// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared 32-source bus: bounded tenure, registered one-hot grant,
// and a guaranteed dead cycle between successive owners.
module bus_arbiter #(
  parameter int NREQ     = 32,
  parameter int SELW     = 5,
  parameter int MAX_HOLD = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            owner_release,
  output logic [NREQ-1:0] grant,
  output logic [SELW-1:0] sel,
  output logic            bus_valid,
  output logic            owner_changed
);

  localparam int HOLDW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HOLDW-1:0] HOLD_LIM = HOLDW'(MAX_HOLD);

  typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

  state_t           state;
  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  owner;
  logic [SELW-1:0]  winner;
  logic [HOLDW-1:0] hold_cnt;
  logic             any_req;
  logic             hold_expired;
  logic             tenure_end;

  // First requester at or after the search start, wrapping modulo NREQ.
  function automatic logic [SELW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [SELW-1:0] start);
    logic [SELW-1:0] idx;
    logic            found;
    rr_pick = start;
    found   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = start + SELW'(k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  always_comb begin
    winner       = rr_pick(req, ptr);
    any_req      = |req;
    hold_expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_LIM);
    tenure_end   = owner_release || !req[owner] || hold_expired;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      owner         <= '0;
      hold_cnt      <= '0;
      grant         <= '0;
      sel           <= '0;
      bus_valid     <= 1'b0;
      owner_changed <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          owner_changed <= 1'b0;
          if (any_req) begin
            owner         <= winner;
            grant         <= NREQ'(1) << winner;
            sel           <= winner;
            bus_valid     <= 1'b1;
            owner_changed <= 1'b1;
            hold_cnt      <= HOLDW'(1);
            state         <= OWN;
          end
        end
        OWN: begin
          owner_changed <= 1'b0;
          if (tenure_end) begin
            // sel is left on the last owner so the mux does not glitch through source 0
            grant     <= '0;
            bus_valid <= 1'b0;
            ptr       <= owner + 1'b1;
            state     <= TURN;
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        TURN: begin
          owner_changed <= 1'b0;
          state         <= IDLE;
        end
        default: begin
          owner_changed <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: a tenure-level reference model queues expected tenures,
// a negedge monitor reconstructs tenures from the DUT outputs and compares them.
module tb_bus_arbiter;

  localparam int NREQ     = 32;
  localparam int SELW     = 5;
  localparam int MAX_HOLD = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic            owner_release = 1'b0;
  logic [NREQ-1:0] grant;
  logic [SELW-1:0] sel;
  logic            bus_valid;
  logic            owner_changed;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int owner;
    int len;
    int start;
  } tenure_t;

  tenure_t exp_q[$];

  // Reference model: who owns the bus, for how long, and how many dead edges remain.
  int m_owner = -1;
  int m_len   = 0;
  int m_start = 0;
  int m_ptr   = 0;
  int m_dead  = 0;
  int m_edge  = 0;

  int cyc;

  bus_arbiter #(.NREQ(NREQ), .SELW(SELW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .owner_release(owner_release),
    .grant        (grant),
    .sel          (sel),
    .bus_valid    (bus_valid),
    .owner_changed(owner_changed)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_len   = 0;
    m_start = 0;
    m_ptr   = 0;
    m_dead  = 0;
    m_edge  = 0;
    exp_q.delete();
  endtask

  // Drive one cycle of stimulus, let the edge happen, and advance the model by that edge.
  task automatic step(input logic [NREQ-1:0] r, input logic rl);
    int w;
    tenure_t t;
    req = r;
    owner_release = rl;
    @(posedge clk);
    m_edge++;
    if (m_owner >= 0) begin
      if (rl || !r[m_owner] || (MAX_HOLD != 0 && m_len == MAX_HOLD)) begin
        t.owner = m_owner;
        t.len   = m_len;
        t.start = m_start;
        exp_q.push_back(t);
        m_ptr   = (m_owner + 1) % NREQ;
        m_owner = -1;
        m_dead  = 1;
      end else begin
        m_len++;
      end
    end else if (m_dead > 0) begin
      m_dead--;
    end else if (r != 0) begin
      w = -1;
      for (int off = 0; off < NREQ; off++)
        if (w < 0 && r[(m_ptr + off) % NREQ]) w = (m_ptr + off) % NREQ;
      m_owner = w;
      m_len   = 1;
      m_start = m_edge;
    end
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_grant", grant, 0);
    check("rst_sel", 32'(sel), 0);
    check("rst_bus_valid", 32'(bus_valid), 0);
    check("rst_owner_changed", 32'(owner_changed), 0);
  endtask

  // Monitor: rebuilds tenures from the outputs and pops the scoreboard when one ends.
  int      mon_owner = -1;
  int      mon_len   = 0;
  int      mon_start = 0;
  int      last_owner = 0;
  int      idx;
  tenure_t e;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_owner  = -1;
      last_owner = 0;
    end else begin
      check("grant_onehot0", 32'($onehot0(grant)), 1);
      check("bus_valid", 32'(bus_valid), 32'(grant != 0));
      if (grant != 0) begin
        idx = 0;
        for (int i = 0; i < NREQ; i++) if (grant[i]) idx = i;
        if (mon_owner < 0) begin
          check("owner_changed_first", 32'(owner_changed), 1);
          mon_owner = idx;
          mon_len   = 1;
          mon_start = cyc;
        end else begin
          check("owner_changed_hold", 32'(owner_changed), 0);
          check("grant_stable", idx, mon_owner);
          mon_len++;
        end
        check("sel_owner", 32'(sel), idx);
        last_owner = idx;
      end else begin
        check("owner_changed_idle", 32'(owner_changed), 0);
        check("sel_hold", 32'(sel), last_owner);
        if (mon_owner >= 0) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tenure_unexpected: got owner %0d len %0d start %0d, expected none",
                     mon_owner, mon_len, mon_start);
          end else begin
            e = exp_q.pop_front();
            check("tenure_owner", mon_owner, e.owner);
            check("tenure_len", mon_len, e.len);
            check("tenure_start", mon_start, e.start);
          end
          mon_owner = -1;
        end
      end
    end
  end

  always @(negedge clk)
    if (rst_n) assert (!$isunknown(dut.ptr)) else $error("FAIL ptr_known: ptr=%h", dut.ptr);

  logic [NREQ-1:0] r;
  logic            rl;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester, released after three cycles.
    repeat (3) step(32'h0000_0001, 1'b0);
    step(32'h0000_0001, 1'b1);
    repeat (4) step('0, 1'b0);

    // Two requesters at opposite ends: ownership alternates and ptr wraps.
    repeat (16) step(32'h8000_0001, 1'b1);
    repeat (4) step('0, 1'b0);

    // Held request with no release: tenures end on the hold limit.
    repeat (16) step(32'h0000_0010, 1'b0);
    repeat (4) step('0, 1'b0);

    // Owner 7 drops its request in its second cycle while 8 waits.
    repeat (2) step(32'h0000_0180, 1'b0);
    repeat (6) step(32'h0000_0100, 1'b0);
    repeat (4) step('0, 1'b0);

    // Everyone requesting, release every second cycle.
    for (int i = 0; i < 140; i++) step('1, 1'(i % 2));
    repeat (4) step('0, 1'b0);

    // Asynchronous reset in the middle of source 12's tenure.
    repeat (3) step(32'h0000_1000, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) step(32'h0000_2000, 1'b0);
    repeat (4) step('0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0:       r = '0;
        1:       r = NREQ'(1) << $urandom_range(0, NREQ - 1);
        2:       r = $urandom & $urandom;
        default: r = $urandom;
      endcase
      rl = ($urandom_range(0, 4) == 0);
      step(r, rl);
    end

    repeat (8) step('0, 1'b0);
    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    check("monitor_idle", 32'(mon_owner < 0), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
